sumres_seq: RTL and testbench



---
 rtl/sumres_pkg.sv | 24 ++
 rtl/sumres_seq_if.sv | 33 +++
 rtl/sumres_nibble.sv | 33 +++
 rtl/sumres_seq.sv | 155 +++++++++++++++
 tb/tb_sumres_seq.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/sumres_pkg.sv
// sumres_pkg: types and constants shared by the multi-precision add/sub
// sequencer, its bus interface and its 4-bit slice.
//   state_t    - sequencer FSM states (IDLE, RUN, DONE)
//   OPE_ADD/SUB - encoding of the operation select
//   NIBBLE_W   - width of one slice
//   cnt_width  - nibble counter width: clog2(n), never less than 1
package sumres_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic OPE_ADD = 1'b0;
    localparam logic OPE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sumres_seq_if.sv
// sumres_seq_if: request/result bundle of the add/sub sequencer.
//   in_start, in_ope, in_a, in_b, in_cy  - request side (driven by master)
//   out_s, out_cy0, out_ovf, out_zero    - registered result
//   out_busy, out_done                   - status / completion pulse
// master = requester, slave = sequencer.
interface sumres_seq_if #(
    parameter int NIBBLES = 4
);
    import sumres_pkg::*;

    logic                          in_start;
    logic                          in_ope;
    logic [NIBBLE_W*NIBBLES-1:0]   in_a;
    logic [NIBBLE_W*NIBBLES-1:0]   in_b;
    logic                          in_cy;
    logic [NIBBLE_W*NIBBLES-1:0]   out_s;
    logic                          out_cy0;
    logic                          out_ovf;
    logic                          out_zero;
    logic                          out_busy;
    logic                          out_done;

    modport master (
        output in_start, in_ope, in_a, in_b, in_cy,
        input  out_s, out_cy0, out_ovf, out_zero, out_busy, out_done
    );

    modport slave (
        input  in_start, in_ope, in_a, in_b, in_cy,
        output out_s, out_cy0, out_ovf, out_zero, out_busy, out_done
    );

endinterface

// File: rtl/sumres_nibble.sv
// sumres_nibble: combinational 4-bit add/subtract slice.
//   a, b  - operand nibbles
//   cin   - carry in
//   ope   - OPE_ADD: a+b+cin, OPE_SUB: a+~b+cin
//   s     - 4-bit sum
//   cout  - carry out of bit 3
//   c3    - carry into bit 3 (cout ^ c3 gives signed overflow on the top nibble)
module sumres_nibble
    import sumres_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    input  logic                ope,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W-1:0] b_eff;
    logic [3:0]          low_sum;

    assign b_eff = (ope == OPE_SUB) ? ~b : b;

    // Low three bits added separately so the carry into bit 3 is visible.
    assign low_sum = {1'b0, a[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, cin};
    assign c3      = low_sum[3];

    assign s[2:0] = low_sum[2:0];
    assign s[3]   = a[3] ^ b_eff[3] ^ c3;
    assign cout   = (a[3] & b_eff[3]) | (c3 & (a[3] ^ b_eff[3]));

endmodule

// File: rtl/sumres_seq.sv
// sumres_seq: wide add/subtract built from one time-multiplexed 4-bit slice.
// Operands are latched on start and processed LS nibble first, one nibble
// per clock, with a registered carry between nibbles. The result and its
// flags are loaded only on the completion edge and held otherwise.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - sumres_seq_if slave port (request, result, busy/done)
module sumres_seq
    import sumres_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sumres_seq_if.slave   bus
);

    localparam int                CNT_W    = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t state_reg;
    state_t state_next;

    logic [NIBBLES-1:0][NIBBLE_W-1:0] a_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] b_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] part_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] final_sum;
    logic                             ope_reg;
    logic                             carry_reg;
    logic [CNT_W-1:0]                 cnt_reg;

    logic [NIBBLES-1:0][NIBBLE_W-1:0] out_s_reg;
    logic                             out_cy0_reg;
    logic                             out_ovf_reg;
    logic                             out_zero_reg;

    logic load_en;
    logic step_en;
    logic last_en;
    logic busy_c;
    logic done_c;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_cout;
    logic                slice_c3;

    sumres_nibble u_slice (
        .a    (a_reg[cnt_reg]),
        .b    (b_reg[cnt_reg]),
        .cin  (carry_reg),
        .ope  (ope_reg),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = bus.in_start ? RUN : IDLE;
            RUN:     state_next = (cnt_reg == LAST_CNT) ? DONE : RUN;
            DONE:    state_next = bus.in_start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        load_en = 1'b0;
        step_en = 1'b0;
        last_en = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_reg)
            IDLE: begin
                load_en = bus.in_start;
            end
            RUN: begin
                busy_c  = 1'b1;
                step_en = 1'b1;
                last_en = (cnt_reg == LAST_CNT);
            end
            DONE: begin
                done_c  = 1'b1;
                load_en = bus.in_start;
            end
            default: ;
        endcase
    end

    // The nibble being computed this cycle is not in part_reg yet, so the
    // completed word is part_reg with the live slice output folded in.
    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_final
            assign final_sum[gi] = (cnt_reg == CNT_W'(gi)) ? slice_s : part_reg[gi];
        end
    endgenerate

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            part_reg     <= '0;
            ope_reg      <= 1'b0;
            carry_reg    <= 1'b0;
            cnt_reg      <= '0;
            out_s_reg    <= '0;
            out_cy0_reg  <= 1'b0;
            out_ovf_reg  <= 1'b0;
            out_zero_reg <= 1'b0;
        end else begin
            if (load_en) begin
                a_reg     <= bus.in_a;
                b_reg     <= bus.in_b;
                ope_reg   <= bus.in_ope;
                carry_reg <= bus.in_cy;
                cnt_reg   <= '0;
            end else if (step_en) begin
                part_reg[cnt_reg] <= slice_s;
                carry_reg         <= slice_cout;
                // Counter parks on the last nibble rather than wrapping.
                if (!last_en) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            if (last_en) begin
                out_s_reg    <= final_sum;
                out_cy0_reg  <= slice_cout;
                out_ovf_reg  <= slice_c3 ^ slice_cout;
                out_zero_reg <= (final_sum == '0);
            end
        end
    end

    assign bus.out_s    = out_s_reg;
    assign bus.out_cy0  = out_cy0_reg;
    assign bus.out_ovf  = out_ovf_reg;
    assign bus.out_zero = out_zero_reg;
    assign bus.out_busy = busy_c;
    assign bus.out_done = done_c;

endmodule

// File: tb/tb_sumres_seq.sv
// tb_sumres_seq: scoreboard bench for sumres_seq with NIBBLES=4.
module tb_sumres_seq;

    localparam int NB = 4;
    localparam int W  = 4 * NB;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cy0;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic clk;
    logic rst_n;

    sumres_seq_if #(.NIBBLES(NB)) bus ();

    sumres_seq #(.NIBBLES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         sb_q[$];
    int           n_cmp    = 0;
    int           n_err    = 0;
    int           done_cnt = 0;
    int           ops_done = 0;
    logic [W-1:0] prev_s   = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: full-width arithmetic, overflow from operand signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ope, input logic cy);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   sum;
        bb     = ope ? ~b : b;
        sum    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cy};
        e.s    = sum[W-1:0];
        e.cy0  = sum[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (e.s[W-1] != a[W-1]);
        e.zero = (e.s == '0);
        return e;
    endfunction

    // Result monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n && bus.out_done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("result s=0x%04h cy0=%0b ovf=%0b zero=%0b (exp s=0x%04h cy0=%0b ovf=%0b zero=%0b)",
                         bus.out_s, bus.out_cy0, bus.out_ovf, bus.out_zero, e.s, e.cy0, e.ovf, e.zero);
                check_val("out_s",    32'(bus.out_s),    32'(e.s));
                check_val("out_cy0",  32'(bus.out_cy0),  32'(e.cy0));
                check_val("out_ovf",  32'(bus.out_ovf),  32'(e.ovf));
                check_val("out_zero", 32'(bus.out_zero), 32'(e.zero));
            end
        end
    end

    // Issue one operation. b2b: drive start in the current (DONE) negedge
    // instead of waiting one. disturb: pulse start and change operands mid-RUN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ope, input logic cy,
                          input bit b2b, input bit disturb);
        exp_t e;
        int   lat;
        int   busy_cnt;
        bit   got;
        if (!b2b) @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_ope   = ope;
        bus.in_cy    = cy;
        bus.in_start = 1'b1;
        e = model(a, b, ope, cy);
        sb_q.push_back(e);
        $display("start a=0x%04h b=0x%04h ope=%0b cy=%0b", a, b, ope, cy);
        lat      = 0;
        busy_cnt = 0;
        got      = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            bus.in_start = 1'b0;
            if (disturb && lat == 2) begin
                bus.in_start = 1'b1;
                bus.in_a     = W'($urandom);
                bus.in_b     = W'($urandom);
                bus.in_ope   = ~ope;
                bus.in_cy    = ~cy;
            end
            if (lat == 2) check_val("hold_s", 32'(bus.out_s), 32'(prev_s));
            if (bus.out_busy) busy_cnt++;
            if (bus.out_done) got = 1;
        end
        bus.in_start = 1'b0;
        if (!got) check_val("done_timeout", 32'd0, 32'd1);
        check_val("latency", 32'(lat - 1), 32'(NB));
        check_val("busy_cycles", 32'(busy_cnt), 32'(NB));
        prev_s = e.s;
        ops_done++;
    endtask

    initial begin
        int dc;
        rst_n        = 1'b0;
        bus.in_start = 1'b0;
        bus.in_ope   = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_cy    = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_s",    32'(bus.out_s),    32'd0);
        check_val("rst_cy0",  32'(bus.out_cy0),  32'd0);
        check_val("rst_ovf",  32'(bus.out_ovf),  32'd0);
        check_val("rst_zero", 32'(bus.out_zero), 32'd0);
        check_val("rst_busy", 32'(bus.out_busy), 32'd0);
        check_val("rst_done", 32'(bus.out_done), 32'd0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
        run_op(16'h00FF, 16'h0000, 1'b0, 1'b1, 0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0);
        run_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 1, 0);
        run_op(16'h1000, 16'h0001, 1'b1, 1'b1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            run_op(W'($urandom), W'($urandom), 1'(k), 1'($urandom_range(0, 1)), 0, 0);
        end
        repeat (4) @(negedge clk);
        check_val("done_pulses", 32'(done_cnt), 32'(ops_done));

        // Asynchronous reset in the middle of RUN, between clock edges.
        @(negedge clk);
        bus.in_a     = 16'h4321;
        bus.in_b     = 16'h1111;
        bus.in_ope   = 1'b0;
        bus.in_cy    = 1'b0;
        bus.in_start = 1'b1;
        sb_q.push_back(model(16'h4321, 16'h1111, 1'b0, 1'b0));
        @(negedge clk);
        bus.in_start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_s",    32'(bus.out_s),    32'd0);
        check_val("arst_cy0",  32'(bus.out_cy0),  32'd0);
        check_val("arst_ovf",  32'(bus.out_ovf),  32'd0);
        check_val("arst_zero", 32'(bus.out_zero), 32'd0);
        check_val("arst_busy", 32'(bus.out_busy), 32'd0);
        check_val("arst_done", 32'(bus.out_done), 32'd0);
        void'(sb_q.pop_back());
        prev_s = '0;
        dc = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_val("no_done_after_rst", 32'(done_cnt), 32'(dc));

        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("final_pulses", 32'(done_cnt), 32'(ops_done));
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
